// File: rtl/btb_predictor_pkg.sv
// Shared constants and default-width entry layout for the branch target buffer.
// The top module re-declares the entry struct with its own parameter widths.
package btb_predictor_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_CTR_W = 2;
    localparam int PC_INC    = 4;

    // Weakly-taken: MSB set, all other counter bits clear.
    localparam logic [DEF_CTR_W-1:0] CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [DEF_XLEN-1:0]  tag;
        logic [DEF_XLEN-1:0]  target;
        logic [DEF_CTR_W-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_predictor_sat_ctr.sv
// Saturating up/down counter next-value logic, shared by all BTB entries
// because at most one entry is updated per cycle.
module btb_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != {CTR_W{1'b1}}) ctr_o = ctr_i + CTR_W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Fully-associative flop-based BTB with 2-bit-style direction counters:
// zero-latency lookup, one-entry-per-cycle update, round-robin replacement.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int XLEN    = DEF_XLEN,
    parameter int CTR_W   = DEF_CTR_W
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            flush
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    // Package constant scaled to CTR_W; requires CTR_W >= 2.
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(CTR_WEAK_TAKEN) << (CTR_W - DEF_CTR_W);

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t           entries_q [ENTRIES];
    entry_t           entries_d [ENTRIES];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             lk_hit, upd_hit, any_free;
    logic [IDX_W-1:0] lk_idx, upd_idx, free_idx, alloc_idx;
    logic [CTR_W-1:0] ctr_next;

    // Parallel tag compare; the duplicate-free invariant keeps matches one-hot,
    // so OR-ing matching indices is a valid one-hot-to-index encoder.
    always_comb begin
        lk_hit   = 1'b0;
        upd_hit  = 1'b0;
        lk_idx   = '0;
        upd_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries_q[i].valid && entries_q[i].tag == lookup_pc) begin
                lk_hit = 1'b1;
                lk_idx = lk_idx | IDX_W'(i);
            end
            if (entries_q[i].valid && entries_q[i].tag == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = upd_idx | IDX_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        alloc_idx = any_free ? free_idx : rr_ptr_q;
    end

    btb_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .ctr_i (entries_q[upd_idx].ctr),
        .inc_i (upd_taken),
        .ctr_o (ctr_next)
    );

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) entries_d[i] = entries_q[i];
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
            rr_ptr_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                entries_d[upd_idx].ctr = ctr_next;
                if (upd_taken) entries_d[upd_idx].target = upd_target;
            end else if (upd_taken) begin
                entries_d[alloc_idx] = '{valid: 1'b1, tag: upd_pc, target: upd_target, ctr: CTR_WEAK};
                if (!any_free) rr_ptr_d = rr_ptr_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= entries_d[i];
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pred_hit    = lk_hit;
    assign pred_taken  = lk_hit & entries_q[lk_idx].ctr[CTR_W-1];
    assign pred_target = pred_taken ? entries_q[lk_idx].target : lookup_pc + XLEN'(PC_INC);

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: reset, allocation, counter saturation,
// round-robin eviction, flush priority and reset abort.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, flush;
    logic [31:0] upd_pc, upd_target;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    btb_predictor #(.ENTRIES(8), .XLEN(32), .CTR_W(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .flush       (flush)
    );

    task automatic check_outputs(input bit eh, input bit et, input logic [31:0] etg, input string tag);
        checks++;
        assert (pred_hit === eh) else begin
            fails++;
            $error("FAIL %s hit: observed %0b expected %0b", tag, pred_hit, eh);
        end
        checks++;
        assert (pred_taken === et) else begin
            fails++;
            $error("FAIL %s taken: observed %0b expected %0b", tag, pred_taken, et);
        end
        checks++;
        assert (pred_target === etg) else begin
            fails++;
            $error("FAIL %s target: observed %h expected %h", tag, pred_target, etg);
        end
    endtask

    task automatic look(input logic [31:0] pc, input bit eh, input bit et, input logic [31:0] etg, input string tag);
        lookup_pc = pc;
        #1;
        check_outputs(eh, et, etg, tag);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit fl);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        flush      = fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; lookup_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush = 1'b0;
        #3;
        check_outputs(1'b0, 1'b0, 32'h104, "reset_0x100");
        @(negedge clk); rstn = 1'b1;
        look(32'h100, 1'b0, 1'b0, 32'h104, "after_reset_0x100");

        // Allocation: same-cycle lookup still sees the old (empty) table.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h200; upd_target = 32'h340; upd_taken = 1'b1;
        look(32'h200, 1'b0, 1'b0, 32'h204, "same_cycle_0x200");
        @(posedge clk); #1; upd_valid = 1'b0;
        look(32'h200, 1'b1, 1'b1, 32'h340, "alloc_0x200");

        // Not-taken decrements to 0 and saturates; target untouched by not-taken.
        update(32'h200, 32'h999, 1'b0, 1'b0);
        look(32'h200, 1'b1, 1'b0, 32'h204, "nt1_ctr01");
        update(32'h200, 32'h999, 1'b0, 1'b0);
        update(32'h200, 32'h999, 1'b0, 1'b0);
        look(32'h200, 1'b1, 1'b0, 32'h204, "nt3_ctr00");
        update(32'h200, 32'h380, 1'b1, 1'b0);
        look(32'h200, 1'b1, 1'b0, 32'h204, "t1_ctr01");
        update(32'h200, 32'h380, 1'b1, 1'b0);
        look(32'h200, 1'b1, 1'b1, 32'h380, "t2_ctr10");
        update(32'h200, 32'h380, 1'b1, 1'b0);
        update(32'h200, 32'h380, 1'b1, 1'b0);
        look(32'h200, 1'b1, 1'b1, 32'h380, "t4_ctr11");
        update(32'h200, 32'h999, 1'b0, 1'b0);
        look(32'h200, 1'b1, 1'b1, 32'h380, "sat_nt_ctr10");
        update(32'h200, 32'h999, 1'b0, 1'b0);
        look(32'h200, 1'b1, 1'b0, 32'h204, "sat_nt_ctr01");

        // Flush wins over a simultaneous allocation.
        update(32'h500, 32'h540, 1'b1, 1'b1);
        look(32'h500, 1'b0, 1'b0, 32'h504, "flush_0x500");
        look(32'h200, 1'b0, 1'b0, 32'h204, "flush_0x200");

        // Nine allocations into eight entries: 0x1000 evicted, rr_ptr becomes 1.
        for (int i = 0; i < 9; i++) update(32'h1000 + 4 * i, 32'h8000 + 4 * i, 1'b1, 1'b0);
        look(32'h1000, 1'b0, 1'b0, 32'h1004, "evict_0x1000");
        for (int i = 1; i < 9; i++) look(32'h1000 + 4 * i, 1'b1, 1'b1, 32'h8000 + 4 * i, "resident");
        // Tenth allocation replaces entry 1 (0x1004), proving rr_ptr was 1.
        update(32'h1024, 32'h8024, 1'b1, 1'b0);
        look(32'h1004, 1'b0, 1'b0, 32'h1008, "evict_0x1004");
        look(32'h1024, 1'b1, 1'b1, 32'h8024, "alloc_0x1024");
        look(32'h1008, 1'b1, 1'b1, 32'h8008, "keep_0x1008");

        // Not-taken miss allocates nothing.
        update(32'h600, 32'h640, 1'b0, 1'b0);
        look(32'h600, 1'b0, 1'b0, 32'h604, "nt_miss_0x600");
        look(32'h1020, 1'b1, 1'b1, 32'h8020, "keep_0x1020");

        // Reset asserted while an update is presented: the write is aborted.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h700; upd_target = 32'h740; upd_taken = 1'b1;
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        look(32'h1008, 1'b0, 1'b0, 32'h100c, "in_reset_0x1008");
        @(negedge clk); rstn = 1'b1;
        look(32'h700, 1'b0, 1'b0, 32'h704, "rst_abort_0x700");
        look(32'h1020, 1'b0, 1'b0, 32'h1024, "rst_0x1020");
        look(32'h1024, 1'b0, 1'b0, 32'h1028, "rst_0x1024");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of BTB entries (power of 2, 2..64).
REQ-002 SHALL have parameter XLEN, default 32, address width.
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width.
REQ-004 SHALL have port clk  input  1  clock, rising-edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port lookup_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 SHALL have port pred_hit  output  1  lookup_pc matches a valid entry.
REQ-008 SHALL have port pred_taken  output  1  prediction is taken.
REQ-009 SHALL have port pred_target  output  XLEN  next-fetch address.
REQ-010 SHALL have port upd_valid  input  1  resolved-branch update strobe.
REQ-011 SHALL have port upd_pc  input  XLEN  PC of the resolved branch.
REQ-012 SHALL have port upd_target  input  XLEN  resolved target address.
REQ-013 SHALL have port upd_taken  input  1  resolved direction.
REQ-014 SHALL have port flush  input  1  synchronous invalidate-all.

Function
REQ-015 Each entry SHALL hold valid (1), tag = full XLEN PC, target (XLEN), ctr (CTR_W).
REQ-016 Lookup SHALL be combinational from registered state: zero-cycle latency.
REQ-017 pred_hit SHALL be 1 iff exactly one valid entry has tag == lookup_pc; a duplicate-free invariant is maintained by REQ-020.
REQ-018 pred_taken SHALL equal pred_hit & ctr[CTR_W-1] of the hitting entry.
REQ-019 pred_target SHALL be the hitting entry's target when pred_taken, else lookup_pc+4, truncated to XLEN.
REQ-020 On upd_valid with upd_pc matching a valid entry: ctr SHALL increment (saturate at all-ones) if upd_taken, else decrement (saturate at 0); target SHALL be overwritten with upd_target only if upd_taken; no allocation.
REQ-021 On upd_valid, miss, upd_taken=1: SHALL allocate the lowest-index invalid entry; if none is invalid, the entry at round-robin pointer rr_ptr; write valid=1, tag=upd_pc, target=upd_target, ctr=weakly-taken (MSB 1, rest 0, i.e. 2'b10).
REQ-022 On upd_valid, miss, upd_taken=0: SHALL make no state change.
REQ-023 rr_ptr (log2 ENTRIES bits) SHALL advance by 1, wrapping ENTRIES-1 -> 0, only when an allocation replaces a valid entry.
REQ-024 Updates SHALL take effect at the next rising edge; a same-cycle lookup of upd_pc returns pre-update contents.
REQ-025 flush=1 SHALL clear all valid bits and rr_ptr at the next edge; flush overrides a simultaneous update; targets/tags/ctrs need not clear.
REQ-026 At most one entry SHALL be written per cycle.

Reset
REQ-027 rstn low SHALL asynchronously clear all valid bits, ctrs and rr_ptr to 0; tags/targets cleared to 0.
REQ-028 During and after reset, with no updates: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-029 Reset asserted mid-update SHALL abort the write; no partial entry becomes valid.

Structure
REQ-030 Shared package SHALL hold CTR_WEAK_TAKEN constant, entry struct/field widths, and PC increment constant 4.
REQ-031 One sub-module btb_sat_ctr (CTR_W-wide saturating up/down update function/logic) SHALL be instantiated per entry or as shared next-value logic.
REQ-032 Storage SHALL be flip-flops (no SRAM macro); match logic a parallel ENTRIES-wide compare plus one-hot-to-index encoder.

Verification
REQ-033 Reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-034 Update pc=0x200,target=0x340,taken=1; next cycle lookup 0x200 -> hit=1, taken=1, target=0x340; same-cycle lookup -> hit=0.
REQ-035 Two not-taken updates on 0x200 (ctr 10->01->00) -> lookup hit=1, taken=0, target=0x204; three taken updates -> ctr saturates at 11, taken=1.
REQ-036 ENTRIES=8: allocate 9 distinct taken PCs 0x1000..0x1020 step 4 -> 0x1000 evicted (miss), 0x1004..0x1020 hit, rr_ptr=1.
REQ-037 flush and update pc=0x500 in same cycle -> next cycle all lookups miss including 0x500.
REQ-038 Not-taken update on unknown pc=0x600 -> no allocation, lookup 0x600 hit=0; rstn pulsed mid-operation -> all entries miss.
